// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-test round controller.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        RESULT,
        FALSE_START,
        DONE
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    localparam logic [15:0] BEST_NONE = 16'hFFFF;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    typedef struct packed {
        logic start;
        logic p1;
        logic p0;
    } key_evt_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAP_MASK), s[15:1]};
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchroniser for an active-low key plus a registered falling-edge press event.
module key_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_press
);

    logic r_s1, r_s2, r_prev, r_press;

    // Idle level of the key is high, so reset the chain high to avoid a phantom press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_prev  <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_s1    <= i_key_n;
            r_s2    <= r_s1;
            r_prev  <= r_s2;
            r_press <= r_prev & ~r_s2;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/reaction_round_ctrl.sv
// Reaction-test round controller: hold-off, stopwatch sequencing, stop-key arbitration, match scoring.
// Optional per-player win counters on score0/score1 are built when REACT_SCOREBOARD_EN is defined.
module reaction_round_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned SEC_CYCLES = 50000000,
    parameter int unsigned TICK_DIV   = 500000,
    parameter int unsigned MIN_WAIT_S = 1,
    parameter int unsigned MAX_WAIT_S = 10,
    parameter int unsigned NUM_ROUNDS = 5,
    parameter int unsigned TIMEOUT_CS = 999
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        start_n,
    input  logic        p0_stop_n,
    input  logic        p1_stop_n,
    output logic        sw_clear,
    output logic        sw_tick,
    output logic        blank,
    output logic        go_led,
    output logic [1:0]  winner,
    output logic [1:0]  false_start,
    output logic [3:0]  round_num,
    output logic [15:0] elapsed_cs,
    output logic [15:0] best_cs,
    output logic        result_valid,
    output logic        match_done,
    output logic [3:0]  score0,
    output logic [3:0]  score1
);

    localparam int          NUM_KEYS     = 3;
    localparam logic [31:0] LP_SEC       = 32'(SEC_CYCLES);
    localparam logic [31:0] LP_TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [31:0] LP_SPAN      = 32'(MAX_WAIT_S - MIN_WAIT_S + 1);
    localparam logic [31:0] LP_MIN       = 32'(MIN_WAIT_S);
    localparam logic [3:0]  LP_ROUNDS    = 4'(NUM_ROUNDS);
    localparam logic [15:0] LP_TIMEOUT   = 16'(TIMEOUT_CS);

    logic [NUM_KEYS-1:0] w_key_n, w_press;
    key_evt_t            w_evt;

    assign w_key_n = {start_n, p1_stop_n, p0_stop_n};
    assign w_evt   = key_evt_t'(w_press);

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_sync_edge u_key (
            .clk     (CLOCK_50),
            .rst_n   (RESET_N),
            .i_key_n (w_key_n[gi]),
            .o_press (w_press[gi])
        );
    end

    state_t      r_state, w_state_nxt;
    logic [15:0] r_lfsr;
    logic [31:0] r_wait_tgt, r_wait_cnt, r_div;
    logic [15:0] r_elapsed, r_best;
    logic [3:0]  r_round;
    logic [1:0]  r_winner, r_false;
    logic        r_sw_clear, r_sw_tick, r_result_valid;

    logic        w_arm_go, w_match_start, w_run_go, w_stop_hit, w_timeout, w_fs_hit, w_tick;
    logic        w_any_stop;
    logic [15:0] w_elapsed_nxt;
    logic [31:0] w_wait_s, w_target;

    assign w_any_stop    = w_evt.p0 | w_evt.p1;
    assign w_wait_s      = ({16'd0, r_lfsr} % LP_SPAN) + LP_MIN;
    assign w_target      = w_wait_s * LP_SEC;
    // The tick is suppressed once the timeout value is reached so the frozen result stays exact.
    assign w_tick        = (r_state == RUN) && (r_div == LP_TICK_LAST) && (r_elapsed != LP_TIMEOUT);
    assign w_elapsed_nxt = w_tick ? r_elapsed + 16'd1 : r_elapsed;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_arm_go      = 1'b0;
        w_match_start = 1'b0;
        w_run_go      = 1'b0;
        w_stop_hit    = 1'b0;
        w_timeout     = 1'b0;
        w_fs_hit      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_evt.start) begin
                    w_arm_go      = 1'b1;
                    w_match_start = 1'b1;
                    w_state_nxt   = ARM;
                end
            end
            ARM: begin
                if (w_any_stop) begin
                    w_fs_hit    = 1'b1;
                    w_state_nxt = FALSE_START;
                end else if (r_wait_cnt == r_wait_tgt - 32'd1) begin
                    w_run_go    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_any_stop) begin
                    w_stop_hit  = 1'b1;
                    w_state_nxt = RESULT;
                end else if (r_elapsed == LP_TIMEOUT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESULT;
                end
            end
            RESULT: begin
                if (r_round == LP_ROUNDS) begin
                    w_state_nxt = DONE;
                end else if (w_evt.start) begin
                    w_arm_go    = 1'b1;
                    w_state_nxt = ARM;
                end
            end
            FALSE_START: begin
                if (w_evt.start) begin
                    w_arm_go    = 1'b1;
                    w_state_nxt = ARM;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_lfsr         <= LFSR_SEED;
            r_wait_tgt     <= '0;
            r_wait_cnt     <= '0;
            r_div          <= '0;
            r_elapsed      <= '0;
            r_best         <= BEST_NONE;
            r_round        <= '0;
            r_winner       <= WIN_NONE;
            r_false        <= '0;
            r_sw_clear     <= 1'b0;
            r_sw_tick      <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_lfsr         <= lfsr_next(r_lfsr);
            r_sw_clear     <= w_arm_go;
            r_sw_tick      <= w_tick;
            r_result_valid <= w_stop_hit | w_timeout;

            if (w_arm_go) begin
                r_wait_tgt <= w_target;
                r_wait_cnt <= '0;
            end else if (r_state == ARM) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end

            // Elapsed keeps the tick that lands on the stop edge, then freezes outside RUN.
            if (w_run_go) begin
                r_div     <= '0;
                r_elapsed <= '0;
            end else if (r_state == RUN) begin
                r_div     <= w_tick ? 32'd0 : r_div + 32'd1;
                r_elapsed <= w_elapsed_nxt;
            end

            if (w_match_start)   r_winner <= WIN_NONE;
            else if (w_stop_hit) r_winner <= {w_evt.p1, w_evt.p0};
            else if (w_timeout)  r_winner <= WIN_NONE;

            if (w_arm_go)      r_false <= '0;
            else if (w_fs_hit) r_false <= {w_evt.p1, w_evt.p0};

            if (w_match_start)   r_round <= '0;
            else if (w_stop_hit) r_round <= r_round + 4'd1;

            if (w_match_start)                               r_best <= BEST_NONE;
            else if (w_stop_hit && (w_elapsed_nxt < r_best)) r_best <= w_elapsed_nxt;
        end
    end

`ifdef REACT_SCOREBOARD_EN
    logic [3:0] r_score0, r_score1;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_score0 <= '0;
            r_score1 <= '0;
        end else if (w_match_start) begin
            r_score0 <= '0;
            r_score1 <= '0;
        end else if (w_stop_hit) begin
            if (w_evt.p0 && (r_score0 != 4'hF)) r_score0 <= r_score0 + 4'd1;
            if (w_evt.p1 && (r_score1 != 4'hF)) r_score1 <= r_score1 + 4'd1;
        end
    end

    assign score0 = r_score0;
    assign score1 = r_score1;
`else
    assign score0 = 4'd0;
    assign score1 = 4'd0;
`endif

    assign sw_clear     = r_sw_clear;
    assign sw_tick      = r_sw_tick;
    assign blank        = (r_state == ARM);
    assign go_led       = (r_state == RUN);
    assign winner       = r_winner;
    assign false_start  = r_false;
    assign round_num    = r_round;
    assign elapsed_cs   = r_elapsed;
    assign best_cs      = r_best;
    assign result_valid = r_result_valid;
    assign match_done   = (r_state == DONE);

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl with small timing parameters.
module tb_reaction_round_ctrl;

    logic        CLOCK_50  = 1'b0;
    logic        RESET_N   = 1'b0;
    logic        start_n   = 1'b1;
    logic        p0_stop_n = 1'b1;
    logic        p1_stop_n = 1'b1;
    logic        sw_clear, sw_tick, blank, go_led, result_valid, match_done;
    logic [1:0]  winner, false_start;
    logic [3:0]  round_num, score0, score1;
    logic [15:0] elapsed_cs, best_cs;

    int n_tests    = 0;
    int n_fail     = 0;
    int g_exp_wait = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    reaction_round_ctrl #(
        .SEC_CYCLES (100),
        .TICK_DIV   (10),
        .MIN_WAIT_S (1),
        .MAX_WAIT_S (10),
        .NUM_ROUNDS (3),
        .TIMEOUT_CS (50)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET_N      (RESET_N),
        .start_n      (start_n),
        .p0_stop_n    (p0_stop_n),
        .p1_stop_n    (p1_stop_n),
        .sw_clear     (sw_clear),
        .sw_tick      (sw_tick),
        .blank        (blank),
        .go_led       (go_led),
        .winner       (winner),
        .false_start  (false_start),
        .round_num    (round_num),
        .elapsed_cs   (elapsed_cs),
        .best_cs      (best_cs),
        .result_valid (result_valid),
        .match_done   (match_done),
        .score0       (score0),
        .score1       (score1)
    );

    // Reference LFSR; m_prev holds the value in effect before the latest clock edge.
    logic [15:0] m_lfsr, m_prev;
    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // keys = {start, p1, p0}; returns on the negedge after the FSM consumed the event
    task automatic press(input logic [2:0] keys);
        if (keys[2]) start_n   = 1'b0;
        if (keys[1]) p1_stop_n = 1'b0;
        if (keys[0]) p0_stop_n = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        start_n   = 1'b1;
        p1_stop_n = 1'b1;
        p0_stop_n = 1'b1;
    endtask

    task automatic do_arm(input string tag);
        press(3'b100);
        chk({tag, "_blank"}, 32'(blank), 1);
        chk({tag, "_swclr"}, 32'(sw_clear), 1);
        chk({tag, "_go"}, 32'(go_led), 0);
        g_exp_wait = int'(m_prev % 16'd10) + 1;
    endtask

    task automatic wait_run(input string tag);
        int k = 0;
        while (!go_led && k < 1200) begin
            @(negedge CLOCK_50);
            k++;
        end
        chk({tag, "_wait"}, 32'(k), 32'(g_exp_wait * 100));
        chk({tag, "_wrange"}, 32'(k >= 100 && k <= 1000), 1);
        chk({tag, "_unblank"}, 32'(blank), 0);
    endtask

    // Press so the stop event reaches the FSM exactly t cycles after RUN entry.
    task automatic stop_at(input int t, input logic [1:0] who);
        repeat (t - 4) @(negedge CLOCK_50);
        press({1'b0, who});
    endtask

    task automatic chk_result(input string tag, input logic [1:0] w, input logic [15:0] el,
                              input logic [3:0] rn, input logic [15:0] best);
        chk({tag, "_rv"}, 32'(result_valid), 1);
        chk({tag, "_winner"}, 32'(winner), 32'(w));
        chk({tag, "_elapsed"}, 32'(elapsed_cs), 32'(el));
        chk({tag, "_round"}, 32'(round_num), 32'(rn));
        chk({tag, "_best"}, 32'(best_cs), 32'(best));
        chk({tag, "_goled"}, 32'(go_led), 0);
        @(negedge CLOCK_50);
        chk({tag, "_rv_pulse"}, 32'(result_valid), 0);
        chk({tag, "_elapsed_hold"}, 32'(elapsed_cs), 32'(el));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctl"}, 32'({sw_clear, sw_tick, blank, go_led, result_valid, match_done}), 0);
        chk({tag, "_win_fs"}, 32'({winner, false_start}), 0);
        chk({tag, "_round"}, 32'(round_num), 0);
        chk({tag, "_elapsed"}, 32'(elapsed_cs), 0);
        chk({tag, "_best"}, 32'(best_cs), 32'h0000_FFFF);
        chk({tag, "_score"}, 32'({score0, score1}), 0);
    endtask

    initial begin
        repeat (3) @(negedge CLOCK_50);
        chk_reset_vals("rst0");
        RESET_N = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("idle_blank", 32'(blank), 0);

        // Round 1: p0 wins at 127 cycles -> 12 cs
        do_arm("r1");
        wait_run("r1");
        stop_at(127, 2'b01);
        chk_result("r1", 2'b01, 16'd12, 4'd1, 16'd12);

        // False start by p1, then retry
        do_arm("fs");
        press(3'b010);
        chk("fs_bits", 32'(false_start), 32'b10);
        chk("fs_blank", 32'(blank), 0);
        chk("fs_round", 32'(round_num), 1);
        repeat (2) @(negedge CLOCK_50);
        do_arm("retry");
        chk("retry_fs_clr", 32'(false_start), 0);
        wait_run("retry");

        // No press: timeout at 50 cs, not counted
        repeat (500) @(negedge CLOCK_50);
        chk("to_still_run", 32'(go_led), 1);
        chk("to_elapsed_pre", 32'(elapsed_cs), 50);
        @(negedge CLOCK_50);
        chk_result("to", 2'b00, 16'd50, 4'd1, 16'd12);

        // Simultaneous press on a tick edge -> tie, tick counted
        do_arm("r2");
        wait_run("r2");
        stop_at(300, 2'b11);
        chk_result("r2", 2'b11, 16'd30, 4'd2, 16'd12);

        // Third valid round ends the match
        do_arm("r3");
        wait_run("r3");
        stop_at(255, 2'b01);
        chk_result("r3", 2'b01, 16'd25, 4'd3, 16'd12);
        chk("done_flag", 32'(match_done), 1);
        repeat (3) @(negedge CLOCK_50);
        chk("done_hold", 32'(match_done), 1);

        // Fresh match from DONE
        do_arm("m2");
        chk("m2_round_clr", 32'(round_num), 0);
        chk("m2_best_clr", 32'(best_cs), 32'h0000_FFFF);
        chk("m2_win_clr", 32'(winner), 0);
        chk("m2_done_clr", 32'(match_done), 0);
        wait_run("m2");
        stop_at(255, 2'b10);
        chk_result("m2", 2'b10, 16'd25, 4'd1, 16'd25);

        // Reset mid-RUN takes effect immediately
        do_arm("ab");
        wait_run("ab");
        repeat (37) @(negedge CLOCK_50);
        chk("ab_running", 32'(go_led), 1);
        #1 RESET_N = 1'b0;
        #1 chk_reset_vals("rst1");
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        chk("post_rst_idle", 32'({blank, go_led, match_done}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_round_ctrl.md
Name: reaction_round_ctrl

Overview:
Round controller for the reaction-test stopwatch datapath: sequences the BCD centisecond stopwatch (clear/tick), generates the pseudo-random 1–10 s hold-off, and arbitrates two players' stop keys (first press wins, false starts detected).
Runs a match of NUM_ROUNDS rounds and tracks the best valid reaction time; sits between the KEY inputs and the stopwatch/segdriver datapath.

Parameters:
SEC_CYCLES, 50000000, clock cycles per second of hold-off
TICK_DIV, 500000, clock cycles per 0.01 s stopwatch tick
MIN_WAIT_S, 1, minimum hold-off in seconds
MAX_WAIT_S, 10, maximum hold-off in seconds
NUM_ROUNDS, 5, valid rounds per match (1..15)
TIMEOUT_CS, 999, centiseconds before a no-response result

Ports:
CLOCK_50  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
start_n  in  1  start/next key, active-low, asynchronous
p0_stop_n  in  1  player 0 stop key, active-low, asynchronous
p1_stop_n  in  1  player 1 stop key, active-low, asynchronous
sw_clear  out  1  one-cycle pulse: zero the stopwatch
sw_tick  out  1  one-cycle pulse per centisecond while running
blank  out  1  display blanked during hold-off
go_led  out  1  high in RUN
winner  out  2  00 none/timeout, 01 p0, 10 p1, 11 tie
false_start  out  2  bit i = player i pressed during hold-off
round_num  out  4  completed valid rounds
elapsed_cs  out  16  binary centiseconds of the current/last round
best_cs  out  16  minimum valid elapsed_cs in the match; 16'hFFFF = none
result_valid  out  1  one-cycle pulse on entry to RESULT
match_done  out  1  high in DONE

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0 except best_cs=16'hFFFF. LFSR = 16'hACE1. Counters = 0.
- Keys: each is synchronised with 2 flops and reduced to a one-cycle press event on its falling edge. Event latency is 3 cycles from the pin.
- LFSR: 16-bit Fibonacci (taps 16,14,13,11). Free-runs every cycle.
- IDLE: start event -> ARM. The same start event clears round_num, best_cs, winner and false_start.
- ARM entry:
  - wait_s = (lfsr % (MAX_WAIT_S-MIN_WAIT_S+1)) + MIN_WAIT_S; load wait target = wait_s*SEC_CYCLES (32-bit).
  - Assert blank.
  - Pulse sw_clear the cycle after entry.
- ARM:
  - Any stop event -> FALSE_START, set the false_start bit(s) of the offender(s).
  - Wait count reaching target -1 -> RUN.
  - Start events are ignored.
- RUN entry: elapsed_cs=0, tick divider=0, go_led=1, blank=0.
- RUN:
  - sw_tick pulses every TICK_DIV cycles; elapsed_cs increments on the same cycle.
  - First stop event -> RESULT. Winner is the player who pressed; both in the same cycle -> 11.
  - A stop event on the same cycle as a tick: the tick is counted.
  - elapsed_cs == TIMEOUT_CS -> RESULT with winner=00.
  - Start events are ignored.
- RESULT entry:
  - Pulse result_valid and freeze elapsed_cs.
  - If winner != 00: round_num+1, and best_cs = min(best_cs, elapsed_cs).
  - Timeout rounds are not counted.
- RESULT:
  - round_num == NUM_ROUNDS -> DONE next cycle.
  - Otherwise a start event -> ARM.
  - Stop events are ignored.
- FALSE_START: round not counted; start event -> ARM (retry) and clears false_start.
- DONE: match_done=1; start event -> ARM with a fresh match (as from IDLE).
- Reset mid-round aborts immediately; no partial state survives.

Optional Feature:
REACT_SCOREBOARD_EN
- Defined: extra outputs score0/score1 (4 bits each) count round wins per player; a tie credits both.
- Each score saturates at 15 and clears on match start.
- Undefined: the ports exist, driven constant 0, and no score registers are built.

Decomposition:
- Package reaction_pkg holds:
  - state enum (IDLE, ARM, RUN, RESULT, FALSE_START, DONE)
  - winner encodings (WIN_NONE, WIN_P0, WIN_P1, WIN_TIE)
  - BEST_NONE = 16'hFFFF
  - LFSR_SEED and tap constants
- One sub-module, key_sync_edge (2-flop synchroniser plus falling-edge detector), instantiated three times.

Test Plan:
All scenarios use SEC_CYCLES=100, TICK_DIV=10, NUM_ROUNDS=3, TIMEOUT_CS=50.
- Reset then start press -> ARM within 4 cycles. RUN entered after wait_s*100 cycles, wait_s in 1..10 and matching the LFSR model.
- RUN, p0 press after 127 cycles -> winner=01, elapsed_cs=12, result_valid single pulse, round_num=1, best_cs=12.
- p0 and p1 pressed on the same clock during RUN -> winner=11, round counted.
- p1 press during ARM -> FALSE_START, false_start=10, round_num unchanged. Next start -> ARM, false_start cleared.
- No press in RUN -> after 500 cycles winner=00, elapsed_cs=50, round_num unchanged, best_cs unchanged.
- Three valid rounds (30, 12, 25 cs) -> best_cs=12, match_done=1. Assert RESET_N low mid-RUN -> all outputs at reset values the same cycle.
